store_buffer: RTL and testbench

//   Posted-store buffer between the MEM-stage control/ALU outputs and the data memory.

---
 rtl/store_buffer.sv | 168 ++++++++++++++++
 tb/tb_store_buffer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-store buffer between MEM-stage control and data memory.
// Queues stores, forwards or stalls overlapping loads, and drains stores when the memory port is idle.
module store_buffer #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         MemRead,
  input  logic                         MemWrite,
  input  logic [DM_ADDRESS-1:0]        a,
  input  logic [DATA_W-1:0]            wd,
  input  logic [2:0]                   Funct3,
  output logic                         stall,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data,
  output logic                         dm_MemRead,
  output logic                         dm_MemWrite,
  output logic [DM_ADDRESS-1:0]        dm_a,
  output logic [DATA_W-1:0]            dm_wd,
  output logic [2:0]                   dm_Funct3,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DM_ADDRESS-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0]     r_data [DEPTH];
  logic [2:0]            r_f3   [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [PTR_W-1:0]      w_idx [DEPTH];
  logic [DEPTH-1:0]      w_word_hit;
  logic                  w_any_hit;
  logic [PTR_W-1:0]      w_young_idx;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_full;
  logic                  w_push;
  logic                  w_fwd_ok;
  logic                  w_issue_rd;
  logic                  w_fwd;
  logic                  w_ld_stall;
  logic                  w_pop;
  logic [DATA_W-1:0]     w_young_data;
  logic [DATA_W-1:0]     w_ext;

  function automatic logic [2:0] f_st_bytes(input logic [2:0] f3);
    case (f3)
      3'b000:  return 3'd1;
      3'b001:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] f_ld_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Slot gi holds the gi-th oldest entry; only the first r_count slots are live.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_idx[gi]      = r_rd_ptr + PTR_W'(gi);
      assign w_word_hit[gi] = (CNT_W'(gi) < r_count) &&
                              (r_addr[w_idx[gi]][DM_ADDRESS-1:2] == a[DM_ADDRESS-1:2]);
    end
  endgenerate

  // Scanning oldest to youngest leaves the youngest word match selected.
  always_comb begin
    w_any_hit   = 1'b0;
    w_young_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_word_hit[k]) begin
        w_any_hit   = 1'b1;
        w_young_idx = w_idx[k];
      end
    end
  end

  assign w_is_load    = MemRead;
  assign w_is_store   = MemWrite & ~MemRead;
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_push       = w_is_store & ~w_full;
  assign w_young_data = r_data[w_young_idx];
  assign w_fwd_ok     = (r_addr[w_young_idx] == a) &&
                        (f_st_bytes(r_f3[w_young_idx]) >= f_ld_bytes(Funct3));
  assign w_issue_rd   = w_is_load & ~w_any_hit;
  assign w_fwd        = w_is_load & w_any_hit & w_fwd_ok;
  assign w_ld_stall   = w_is_load & w_any_hit & ~w_fwd_ok;
  assign w_pop        = ~w_issue_rd & ~w_push & (r_count != '0);

  always_comb begin
    case (Funct3)
      3'b000:  w_ext = {{(DATA_W-8){w_young_data[7]}}, w_young_data[7:0]};
      3'b001:  w_ext = {{(DATA_W-16){w_young_data[15]}}, w_young_data[15:0]};
      3'b100:  w_ext = {{(DATA_W-8){1'b0}}, w_young_data[7:0]};
      3'b101:  w_ext = {{(DATA_W-16){1'b0}}, w_young_data[15:0]};
      default: w_ext = w_young_data;
    endcase
  end

  // rst_n gates the outputs so a request held during reset drives nothing.
  always_comb begin
    stall       = 1'b0;
    fwd_hit     = 1'b0;
    fwd_data    = '0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_a        = '0;
    dm_wd       = '0;
    dm_Funct3   = '0;
    if (rst_n) begin
      stall      = w_ld_stall | (w_is_store & w_full);
      fwd_hit    = w_fwd;
      dm_MemRead = w_issue_rd;
      if (w_fwd) begin
        fwd_data = w_ext;
      end
      if (w_pop) begin
        dm_MemWrite = 1'b1;
        dm_a        = r_addr[r_rd_ptr];
        dm_wd       = r_data[r_rd_ptr];
        dm_Funct3   = r_f3[r_rd_ptr];
      end else if (w_is_load) begin
        dm_a      = a;
        dm_Funct3 = Funct3;
      end
    end
  end

  assign count = r_count;
  assign empty = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count  <= r_count + 1'b1;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count - 1'b1;
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= a;
      r_data[r_wr_ptr] <= wd;
      r_f3[r_wr_ptr]   <= Funct3;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic compared against a queue/byte-memory reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [8:0]  a = '0;
  logic [31:0] wd = '0;
  logic [2:0]  Funct3 = '0;
  logic        stall, fwd_hit, dm_MemRead, dm_MemWrite, empty;
  logic [31:0] fwd_data, dm_wd;
  logic [8:0]  dm_a;
  logic [2:0]  dm_Funct3, count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [8:0]  ad;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  logic [7:0] arch_mem [520];
  logic [7:0] phys_mem [520];

  store_buffer #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .a(a), .wd(wd), .Funct3(Funct3), .stall(stall), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
    .dm_a(dm_a), .dm_wd(dm_wd), .dm_Funct3(dm_Funct3), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [51:0] obs();
    return {stall, fwd_hit, dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3, count, empty};
  endfunction

  function automatic logic [51:0] mk(input logic st, input logic fh, input logic rd, input logic wr,
                                     input logic [8:0] ad, input logic [31:0] d, input logic [2:0] f,
                                     input logic [2:0] cnt, input logic emp);
    return {st, fh, rd, wr, ad, d, f, cnt, emp};
  endfunction

  function automatic int st_w(input logic [2:0] f);
    return (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
  endfunction

  function automatic int ld_w(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] raw);
    case (f)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] arch_raw(input logic [8:0] ad);
    int i = int'(ad);
    return {arch_mem[i+3], arch_mem[i+2], arch_mem[i+1], arch_mem[i]};
  endfunction

  function automatic logic [31:0] phys_raw(input logic [8:0] ad);
    int i = int'(ad);
    return {phys_mem[i+3], phys_mem[i+2], phys_mem[i+1], phys_mem[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [8:0] ad,
                        input logic [31:0] d, input logic [2:0] f);
    MemRead = rd; MemWrite = wr; a = ad; wd = d; Funct3 = f;
    #3;
  endtask

  task automatic drain_all(input string tag);
    int n = 0;
    set_in(0, 0, 0, 0, 0);
    while (empty !== 1'b1 && n < 12) begin
      tick();
      set_in(0, 0, 0, 0, 0);
      n++;
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_err++;
      $display("FAIL %s_drain_timeout: empty=%b count=%0d, required empty=1", tag, empty, count);
    end
    tick();
  endtask

  task automatic test_reset();
    set_in(1, 1, 9'h10, 32'h1234, 3'b010);
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 1) || fwd_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h fwd %h, required %h fwd 0", obs(), fwd_data, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_drain();
    set_in(0, 1, 9'h10, 32'hDEADBEEF, 3'b010);
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
      n_err++; $display("FAIL drain_push: got %h required %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    tick();
    set_in(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 1, 9'h10, 32'hDEADBEEF, 3'b010, 1, 0)) begin
      n_err++; $display("FAIL drain_write: got %h required %h", obs(), mk(0, 0, 0, 1, 9'h10, 32'hDEADBEEF, 3'b010, 1, 0));
    end
    tick();
    set_in(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
      n_err++; $display("FAIL drain_empty: got %h required %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    tick();
    $display("txn drain SW 0x10 done");
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 9'(4 * i), 32'(i + 1), 3'b010);
      n_cmp++;
      if (stall !== 1'b0 || dm_MemWrite !== 1'b0) begin
        n_err++; $display("FAIL full_fill%0d: stall=%b wr=%b required 0/0", i, stall, dm_MemWrite);
      end
      tick();
    end
    set_in(0, 1, 9'h20, 32'h20, 3'b010);
    n_cmp++;
    if (obs() !== mk(1, 0, 0, 1, 9'h0, 32'd1, 3'b010, 4, 0)) begin
      n_err++; $display("FAIL full_stall: got %h required %h", obs(), mk(1, 0, 0, 1, 9'h0, 32'd1, 3'b010, 4, 0));
    end
    tick();
    set_in(0, 1, 9'h20, 32'h20, 3'b010);
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 3, 0)) begin
      n_err++; $display("FAIL full_accept: got %h required %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 3, 0));
    end
    tick();
    set_in(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 1, 9'h4, 32'd2, 3'b010, 4, 0)) begin
      n_err++; $display("FAIL full_refill: got %h required %h", obs(), mk(0, 0, 0, 1, 9'h4, 32'd2, 3'b010, 4, 0));
    end
    tick();
    drain_all("full");
    $display("txn full-buffer sequence done");
  endtask

  task automatic test_forward();
    set_in(0, 1, 9'h40, 32'h000080FF, 3'b010);
    tick();
    set_in(1, 0, 9'h40, 0, 3'b000);
    n_cmp++;
    if (obs() !== mk(0, 1, 0, 1, 9'h40, 32'h000080FF, 3'b010, 1, 0) || fwd_data !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL fwd_lb: got %h fwd %h required %h fwd ffffffff", obs(), fwd_data,
                        mk(0, 1, 0, 1, 9'h40, 32'h000080FF, 3'b010, 1, 0));
    end
    set_in(1, 0, 9'h40, 0, 3'b101);
    n_cmp++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h000080FF) begin
      n_err++; $display("FAIL fwd_lhu: hit=%b data=%h required 1 000080ff", fwd_hit, fwd_data);
    end
    tick();
    drain_all("fwd");
    $display("txn forward LB/LHU 0x40 done");
  endtask

  task automatic test_partial();
    set_in(0, 1, 9'h41, 32'hAB, 3'b000);
    tick();
    set_in(1, 0, 9'h40, 0, 3'b010);
    n_cmp++;
    if (obs() !== mk(1, 0, 0, 1, 9'h41, 32'hAB, 3'b000, 1, 0)) begin
      n_err++; $display("FAIL partial_stall: got %h required %h", obs(), mk(1, 0, 0, 1, 9'h41, 32'hAB, 3'b000, 1, 0));
    end
    tick();
    set_in(1, 0, 9'h40, 0, 3'b010);
    n_cmp++;
    if (obs() !== mk(0, 0, 1, 0, 9'h40, 0, 3'b010, 0, 1)) begin
      n_err++; $display("FAIL partial_issue: got %h required %h", obs(), mk(0, 0, 1, 0, 9'h40, 0, 3'b010, 0, 1));
    end
    tick();
    drain_all("partial");
    $display("txn partial overlap SB 0x41 / LW 0x40 done");
  endtask

  task automatic test_youngest();
    set_in(0, 1, 9'h50, 32'h1, 3'b010);
    tick();
    set_in(0, 1, 9'h50, 32'h2, 3'b010);
    tick();
    set_in(1, 0, 9'h50, 0, 3'b010);
    n_cmp++;
    if (obs() !== mk(0, 1, 0, 1, 9'h50, 32'h1, 3'b010, 2, 0) || fwd_data !== 32'h2) begin
      n_err++; $display("FAIL youngest: got %h fwd %h required %h fwd 2", obs(), fwd_data,
                        mk(0, 1, 0, 1, 9'h50, 32'h1, 3'b010, 2, 0));
    end
    tick();
    drain_all("young");
    $display("txn youngest-match LW 0x50 done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 9'(9'h60 + 4 * i), 32'(i), 3'b010);
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    n_cmp++;
    if (count !== 3'd3 || dm_MemWrite !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: count=%0d wr=%b required 3/1", count, dm_MemWrite);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
      n_err++; $display("FAIL rstmid_now: got %h required %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0);
      n_cmp++;
      if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
        n_err++; $display("FAIL rstmid_idle%0d: got %h required %h", i, obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      tick();
    end
    $display("txn reset mid-drain done");
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t y;
    logic rd, wr, found, e_st, e_fh, e_rd, e_wr, push;
    logic [8:0] ad, e_a;
    logic [31:0] d, e_wd;
    logic [2:0] f, e_f;
    int r, sz;
    logic [2:0] ld_codes [5];
    ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
    ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;
    for (int i = 0; i < 520; i++) begin
      arch_mem[i] = 8'd0; phys_mem[i] = 8'd0;
    end
    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 99));
      rd = (r >= 45 && r < 80);
      wr = (r < 45) || (rd && $urandom_range(0, 4) == 0);
      d = $urandom;
      f = rd ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      ad = 9'(9'h100 + 4 * $urandom_range(0, 7));
      if ((rd ? ld_w(f) : st_w(f)) == 1) ad = ad + 9'($urandom_range(0, 3));
      else if ((rd ? ld_w(f) : st_w(f)) == 2) ad = ad + 9'(2 * $urandom_range(0, 1));
      set_in(rd, wr, ad, d, f);

      sz = q.size();
      e_st = 0; e_fh = 0; e_rd = 0; e_wr = 0; e_a = 0; e_wd = 0; e_f = 0; push = 0;
      found = 0; y = '0;
      if (rd) begin
        for (int k = sz - 1; k >= 0; k--) begin
          if (q[k].ad[8:2] == ad[8:2]) begin found = 1; y = q[k]; break; end
        end
        if (!found) e_rd = 1;
        else if (y.ad == ad && st_w(y.f) >= ld_w(f)) e_fh = 1;
        else e_st = 1;
        e_a = ad; e_f = f;
      end else if (wr) begin
        if (sz == DEPTH) e_st = 1;
        else push = 1;
      end
      if (!e_rd && !push && sz > 0) begin
        e_wr = 1; e_a = q[0].ad; e_wd = q[0].d; e_f = q[0].f;
      end

      n_cmp++;
      if (obs() !== mk(e_st, e_fh, e_rd, e_wr, e_a, e_wd, e_f, 3'(sz), sz == 0)) begin
        n_err++; $display("FAIL rand_cycle%0d: got %h required %h", t, obs(),
                          mk(e_st, e_fh, e_rd, e_wr, e_a, e_wd, e_f, 3'(sz), sz == 0));
      end
      if (e_fh) begin
        n_cmp++;
        if (fwd_data !== ext(f, arch_raw(ad))) begin
          n_err++; $display("FAIL rand_fwd%0d: got %h required %h", t, fwd_data, ext(f, arch_raw(ad)));
        end
      end
      if (e_rd && dm_MemRead === 1'b1) begin
        n_cmp++;
        if (ext(f, phys_raw(ad)) !== ext(f, arch_raw(ad))) begin
          n_err++; $display("FAIL rand_memread%0d: memory %h required %h", t, ext(f, phys_raw(ad)), ext(f, arch_raw(ad)));
        end
      end
      if (dm_MemWrite === 1'b1) begin
        for (int b = 0; b < st_w(dm_Funct3); b++) phys_mem[int'(dm_a) + b] = dm_wd[8*b +: 8];
      end
      $display("txn %0d rd=%0d wr=%0d a=%h f=%0d cnt=%0d stall=%0d hit=%0d", t, rd, wr, ad, f, count, stall, fwd_hit);
      tick();
      if (push) begin
        q.push_back('{ad: ad, d: d, f: f});
        for (int b = 0; b < st_w(f); b++) arch_mem[int'(ad) + b] = d[8*b +: 8];
      end
      if (e_wr) void'(q.pop_front());
    end
    drain_all("rand");
  endtask

  initial begin
    test_reset();
    test_drain();
    test_full();
    test_forward();
    test_partial();
    test_youngest();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
